// File: rtl/k_sqr_dist_acc_if.sv
// k_sqr_dist_acc_if
//   Handshake bundle for the k-means squared-distance accumulator.
//   Term input side (valid/ready) and distance output side (valid/ready)
//   plus the sticky saturation flag.
//   Signals:
//     in_valid   upstream has a squared term on `in`
//     in_ready   accumulator can take a term this cycle
//     in[15:0]   FP16 squared term {sign,exp[4:0],frac[9:0]}
//     out_valid  `out` holds a completed distance
//     out_ready  consumer takes `out` this cycle
//     out[15:0]  FP16 accumulated distance (sign always 0)
//     ovf        the distance on `out` saturated
//   Modports:
//     slave  - the accumulator itself
//     master - the environment driving terms and consuming distances
interface k_sqr_dist_acc_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        ovf;

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, ovf
  );

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, ovf
  );
endinterface

// File: rtl/k_sqr_dist_acc.sv
// k_sqr_dist_acc
//   Sums DIMS positive FP16 squared terms into one FP16 squared distance and
//   presents it on a valid/ready output. The adder is positive-only: sign
//   bits are ignored, exp==0 is zero, no subnormals, NaN or Inf. A result
//   exponent above 30 saturates to 16'h7BFF and raises the sticky ovf flag
//   for that distance.
//   Optional feature macro: KSQ_ACC_ROUND_EN
//     defined   - round to nearest, ties away from zero, on the guard bit
//     undefined - truncate (no rounding logic at all)
//   Ports:
//     clk  in   rising-edge clock
//     rst  in   asynchronous active-high reset
//     bus  k_sqr_dist_acc_if.slave (in_valid/in_ready/in, out_valid/
//          out_ready/out, ovf)
//   Parameters:
//     DIMS   terms summed per distance (>=1)
//     CNT_W  term-counter width, must hold DIMS-1
module k_sqr_dist_acc #(
  parameter int DIMS  = 2,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  k_sqr_dist_acc_if.slave        bus
);

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIMS - 1);

`ifdef KSQ_ACC_ROUND_EN
  // Round-to-nearest on the guard bit; a fraction wrap bumps the exponent,
  // which may push the result into saturation afterwards.
  function automatic logic [15:0] rnd(input logic [5:0] e,
                                      input logic [9:0] f,
                                      input logic       g);
    logic [10:0] fi;
    fi = {1'b0, f} + {10'd0, g};
    if (fi[10]) rnd = {e + 6'd1, 10'd0};
    else        rnd = {e, fi[9:0]};
  endfunction
`endif

  // Returns {ovf, result}. Both operands are treated as positive.
  function automatic logic [16:0] fpadd(input logic [15:0] a,
                                        input logic [15:0] b);
    logic [4:0]  ea, eb, e_big, e_small, diff;
    logic [10:0] s_big, s_small;
    logic [5:0]  e_res;
    logic [9:0]  f_res;
`ifdef KSQ_ACC_ROUND_EN
    logic [11:0] small_al;
    logic [12:0] sum;
    logic [15:0] r;
`else
    logic [10:0] small_al;
    logic [11:0] sum;
`endif
    ea = a[14:10];
    eb = b[14:10];
    if (ea >= eb) begin
      e_big   = ea;
      e_small = eb;
      s_big   = {1'b1, a[9:0]};
      s_small = {1'b1, b[9:0]};
    end else begin
      e_big   = eb;
      e_small = ea;
      s_big   = {1'b1, b[9:0]};
      s_small = {1'b1, a[9:0]};
    end
    // A zero operand contributes nothing; both zero leaves e_big==0 too.
    if (e_big == 5'd0)   s_big   = 11'd0;
    if (e_small == 5'd0) s_small = 11'd0;
    diff = e_big - e_small;
`ifdef KSQ_ACC_ROUND_EN
    // One extra bit below the LSB keeps the guard through alignment.
    small_al = {s_small, 1'b0} >> diff;
    sum      = {1'b0, s_big, 1'b0} + {1'b0, small_al};
    if (sum[12]) begin
      e_res = {1'b0, e_big} + 6'd1;
      r     = rnd({1'b0, e_big} + 6'd1, sum[11:2], sum[1]);
    end else begin
      e_res = {1'b0, e_big};
      r     = rnd({1'b0, e_big}, sum[10:1], sum[0]);
    end
    e_res = r[15:10];
    f_res = r[9:0];
`else
    // Shifts of 11 or more clear the operand entirely.
    small_al = s_small >> diff;
    sum      = {1'b0, s_big} + {1'b0, small_al};
    if (sum[11]) begin
      e_res = {1'b0, e_big} + 6'd1;
      f_res = sum[10:1];
    end else begin
      e_res = {1'b0, e_big};
      f_res = sum[9:0];
    end
`endif
    if (e_res > 6'd30) fpadd = {1'b1, 16'h7BFF};
    else               fpadd = {1'b0, 1'b0, e_res[4:0], f_res};
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      acc_q, acc_d;
  logic [15:0]      out_q, out_d;
  logic             ovf_q, ovf_d;
  logic [16:0]      add_res;
  logic             in_ready_o, out_valid_o;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
      cnt_q   <= '0;
      acc_q   <= 16'h0000;
      out_q   <= 16'h0000;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    add_res = fpadd(acc_q, bus.in);
    case (state_q)
      ACC: begin
        if (bus.in_valid) begin
          // First term of a distance restarts the sticky flag.
          ovf_d = (cnt_q == '0) ? add_res[16] : (ovf_q | add_res[16]);
          if (cnt_q == LAST) begin
            out_d   = add_res[15:0];
            acc_d   = 16'h0000;
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            acc_d = add_res[15:0];
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  // Handshake outputs decode from state only
  always_comb begin
    in_ready_o  = (state_q == ACC);
    out_valid_o = (state_q == HOLD);
  end

  assign bus.in_ready  = in_ready_o;
  assign bus.out_valid = out_valid_o;
  assign bus.out       = out_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_k_sqr_dist_acc.sv
// tb_k_sqr_dist_acc
//   Table of term pairs with expected distances, plus hand-written HOLD
//   stall and mid-accumulation reset sequences. Expected distances are
//   queued when the last term of a distance is driven and popped when the
//   accumulator presents its output.
module tb_k_sqr_dist_acc;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_out;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [15:0] out;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  exp_t sb[$];

  k_sqr_dist_acc_if bus();

  k_sqr_dist_acc #(.DIMS(2), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Called at a negedge; returns at the negedge after the term was taken.
  task automatic drive_term(input logic [15:0] d);
    int t;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_vec++;
      n_err++;
      $display("FAIL in_ready_timeout: got %b, expected 1", bus.in_ready);
    end
    bus.in       = d;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] o, input logic v);
    exp_t e;
    e.out = o;
    e.ovf = v;
    sb.push_back(e);
  endtask

  task automatic collect(input string name);
    int   t;
    exp_t e;
    t = 0;
    while (bus.out_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_sb_empty: got output %h, expected none", name, bus.out);
      return;
    end
    e = sb.pop_front();
    if (t >= 20) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_out_valid_timeout: got %b, expected 1", name, bus.out_valid);
      return;
    end
    chk({name, "_out"}, bus.out, e.out);
    chk({name, "_ovf"}, {15'd0, bus.ovf}, {15'd0, e.ovf});
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({name, "_in_ready_after"}, {15'd0, bus.in_ready}, 16'd1);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{16'h3C00, 16'h3C00, 16'h4000, 1'b0};
    vecs[1] = '{16'h3C00, 16'h3800, 16'h3E00, 1'b0};
    vecs[2] = '{16'h0000, 16'h4200, 16'h4200, 1'b0};
    vecs[3] = '{16'hBC00, 16'h3C00, 16'h4000, 1'b0};
    vecs[4] = '{16'h7800, 16'h7800, 16'h7BFF, 1'b1};
    vecs[5] = '{16'h3C00, 16'h3C00, 16'h4000, 1'b0};
`ifdef KSQ_ACC_ROUND_EN
    vecs[6] = '{16'h3C00, 16'h1000, 16'h3C01, 1'b0};
`else
    vecs[6] = '{16'h3C00, 16'h1000, 16'h3C00, 1'b0};
`endif

    n_vec         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in        = 16'h0000;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("rst_in_ready",  {15'd0, bus.in_ready},  16'd1);
    chk("rst_out",       bus.out,                16'h0000);
    chk("rst_ovf",       {15'd0, bus.ovf},       16'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      drive_term(vecs[i].a);
      drive_term(vecs[i].b);
      push_exp(vecs[i].exp_out, vecs[i].exp_ovf);
      chk($sformatf("v%0d_latency_valid", i), {15'd0, bus.out_valid}, 16'd1);
      chk($sformatf("v%0d_hold_in_ready", i), {15'd0, bus.in_ready},  16'd0);
      collect($sformatf("v%0d", i));
    end

    // Stall in HOLD: output stable, stray in_valid pulses ignored.
    drive_term(16'h3C00);
    drive_term(16'h3800);
    push_exp(16'h3E00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      bus.in       = 16'h4000;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk($sformatf("stall%0d_out", k),      bus.out,                16'h3E00);
      chk($sformatf("stall%0d_valid", k),    {15'd0, bus.out_valid}, 16'd1);
      chk($sformatf("stall%0d_in_ready", k), {15'd0, bus.in_ready},  16'd0);
    end
    collect("stall");
    drive_term(16'h3C00);
    drive_term(16'h3C00);
    push_exp(16'h4000, 1'b0);
    collect("after_stall");

    // Saturate, then reset with one term pending.
    drive_term(16'h7800);
    drive_term(16'h7800);
    push_exp(16'h7BFF, 1'b1);
    collect("pre_rst_sat");
    drive_term(16'h3C00);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("arst_in_ready",  {15'd0, bus.in_ready},  16'd1);
    chk("arst_out",       bus.out,                16'h0000);
    chk("arst_ovf",       {15'd0, bus.ovf},       16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive_term(16'h4000);
    drive_term(16'h4000);
    push_exp(16'h4400, 1'b0);
    collect("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
